// File: rtl/backscatter_pkg.sv
// Shared types and default timing constants for the backscatter codec.
// Holds the controller state encoding and the pulse-width classifier.
package backscatter_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_MEAS,
    ARMED,
    TX
  } state_e;

  typedef enum logic [1:0] {
    SYM_0,
    SYM_1,
    SYM_BAD
  } sym_e;

  localparam int unsigned DEF_BIT0_LO  = 400;
  localparam int unsigned DEF_BIT0_HI  = 600;
  localparam int unsigned DEF_BIT1_LO  = 1200;
  localparam int unsigned DEF_BIT1_HI  = 1600;
  localparam int unsigned DEF_TX_START = 448;
  localparam int unsigned DEF_TX_STOP  = 6000;
  localparam int unsigned DEF_SUB_HALF = 25;
  localparam int unsigned DEF_BIT_CYC  = 500;

  // Bounds are inclusive; the width is zero-extended so the compare stays unsigned.
  function automatic sym_e classify(input int unsigned width,
                                    input int unsigned b0_lo, input int unsigned b0_hi,
                                    input int unsigned b1_lo, input int unsigned b1_hi);
    if (width >= b0_lo && width <= b0_hi) return SYM_0;
    if (width >= b1_lo && width <= b1_hi) return SYM_1;
    return SYM_BAD;
  endfunction

endpackage

// File: rtl/backscatter_codec_subcarrier_gen.sv
// Square-wave subcarrier: toggles every SUB_HALF enabled clocks, starting low.
// Phase is held at zero whenever enable is low.
module subcarrier_gen #(
  parameter int unsigned SUB_HALF = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic sc
);

  localparam int unsigned    DIV_W    = (SUB_HALF > 1) ? $clog2(SUB_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SUB_HALF - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sc_q, sc_d;

  always_comb begin
    div_d = div_q;
    sc_d  = sc_q;
    if (!enable) begin
      div_d = '0;
      sc_d  = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      sc_d  = ~sc_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      sc_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      sc_q  <= sc_d;
    end
  end

  assign sc = sc_q;

endmodule

// File: rtl/backscatter_codec.sv
// Tag-side codec: classifies downlink pulse widths, matches a header, then
// backscatters an OOK-on-subcarrier payload. Optional: BACKSCATTER_ARM_TIMEOUT_EN.
module backscatter_codec
  import backscatter_pkg::*;
#(
  parameter int unsigned          CNT_W       = 16,
  parameter int unsigned          BIT0_LO     = DEF_BIT0_LO,
  parameter int unsigned          BIT0_HI     = DEF_BIT0_HI,
  parameter int unsigned          BIT1_LO     = DEF_BIT1_LO,
  parameter int unsigned          BIT1_HI     = DEF_BIT1_HI,
  parameter int unsigned          HDR_LEN     = 4,
  parameter logic [HDR_LEN-1:0]   HDR_PATTERN = 4'b1010,
  parameter int unsigned          TX_START    = DEF_TX_START,
  parameter int unsigned          TX_STOP     = DEF_TX_STOP,
  parameter int unsigned          SUB_HALF    = DEF_SUB_HALF,
  parameter int unsigned          BIT_CYC     = DEF_BIT_CYC,
  parameter int unsigned          TX_BITS     = 8,
  parameter int unsigned          ARM_TIMEOUT = 65535
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               trigger_signal,
  input  logic [TX_BITS-1:0] tx_payload,
  output logic               output_signal,
  output logic               send,
  output logic [CNT_W-1:0]   data,
  output logic [4:0]         rx_len,
  output logic               hdr_hit
);

  localparam int unsigned       BIDX_W    = (TX_BITS > 1) ? $clog2(TX_BITS) : 1;
  localparam int unsigned       BTMR_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0]  START_C   = CNT_W'(TX_START);
  localparam logic [CNT_W-1:0]  STOP_C    = CNT_W'(TX_STOP);
  localparam logic [4:0]        HDR_LEN_C = 5'(HDR_LEN);
  localparam logic [BIDX_W-1:0] BIDX_TOP  = BIDX_W'(TX_BITS - 1);
  localparam logic [BTMR_W-1:0] BTMR_LAST = BTMR_W'(BIT_CYC - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     data_q, data_d;
  logic [4:0]           rx_len_q, rx_len_d;
  logic [HDR_LEN-1:0]   shift_q, shift_d;
  logic                 hdr_hit_q, hdr_hit_d;
  logic                 out_q, out_d;
  logic [TX_BITS-1:0]   payload_q, payload_d;
  logic [BIDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [BTMR_W-1:0]    bit_tmr_q, bit_tmr_d;
  logic                 exhausted_q, exhausted_d;

  sym_e                 sym;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 window;
  logic                 sc;

`ifdef BACKSCATTER_ARM_TIMEOUT_EN
  localparam int unsigned      TMO_W    = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_arm_timeout;
  assign unused_arm_timeout = ^ARM_TIMEOUT;
`endif

  assign sym     = classify(32'(cnt_q), BIT0_LO, BIT0_HI, BIT1_LO, BIT1_HI);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign window  = (state_q == TX) && (cnt_q > START_C) && (cnt_q <= STOP_C);

  subcarrier_gen #(.SUB_HALF(SUB_HALF)) u_subcarrier (
    .clock  (clock),
    .reset  (reset),
    .enable (window),
    .sc     (sc)
  );

  // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rx_len_d    = rx_len_q;
    shift_d     = shift_q;
    hdr_hit_d   = 1'b0;
    out_d       = 1'b0;
    payload_d   = payload_q;
    bit_idx_d   = bit_idx_q;
    bit_tmr_d   = bit_tmr_q;
    exhausted_d = exhausted_q;
`ifdef BACKSCATTER_ARM_TIMEOUT_EN
    tmo_d       = '0;
`endif

    unique case (state_q)
      RX_IDLE: begin
        if (trigger_signal) begin
          state_d = RX_MEAS;
          cnt_d   = CNT_W'(1);
        end
      end

      RX_MEAS: begin
        if (trigger_signal) begin
          cnt_d = cnt_inc;
        end else begin
          data_d  = cnt_q;
          state_d = RX_IDLE;
          if (sym == SYM_BAD) begin
            shift_d  = '0;
            rx_len_d = '0;
          end else begin
            shift_d  = (shift_q << 1) | HDR_LEN'(sym == SYM_1);
            rx_len_d = (rx_len_q == 5'd31) ? rx_len_q : rx_len_q + 5'd1;
          end
          // Match on the value that includes the bit just classified.
          if (rx_len_d >= HDR_LEN_C && shift_d == HDR_PATTERN) begin
            hdr_hit_d = 1'b1;
            payload_d = tx_payload;
            state_d   = ARMED;
          end
        end
      end

      ARMED: begin
        if (trigger_signal) begin
          state_d     = TX;
          cnt_d       = CNT_W'(1);
          bit_idx_d   = BIDX_TOP;
          bit_tmr_d   = '0;
          exhausted_d = 1'b0;
        end
`ifdef BACKSCATTER_ARM_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d  = RX_IDLE;
          rx_len_d = '0;
          shift_d  = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      TX: begin
        if (trigger_signal) begin
          cnt_d = cnt_inc;
          out_d = window && sc && payload_q[bit_idx_q] && !exhausted_q;
          if (window && !exhausted_q) begin
            if (bit_tmr_q == BTMR_LAST) begin
              bit_tmr_d = '0;
              if (bit_idx_q == '0) exhausted_d = 1'b1;
              else                 bit_idx_d   = bit_idx_q - 1'b1;
            end else begin
              bit_tmr_d = bit_tmr_q + 1'b1;
            end
          end
        end else begin
          state_d  = RX_IDLE;
          rx_len_d = '0;
          shift_d  = '0;
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  // NOTE: state registers take non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      rx_len_q    <= '0;
      shift_q     <= '0;
      hdr_hit_q   <= 1'b0;
      out_q       <= 1'b0;
      payload_q   <= '0;
      bit_idx_q   <= '0;
      bit_tmr_q   <= '0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      rx_len_q    <= rx_len_d;
      shift_q     <= shift_d;
      hdr_hit_q   <= hdr_hit_d;
      out_q       <= out_d;
      payload_q   <= payload_d;
      bit_idx_q   <= bit_idx_d;
      bit_tmr_q   <= bit_tmr_d;
      exhausted_q <= exhausted_d;
    end
  end

`ifdef BACKSCATTER_ARM_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  assign output_signal = out_q;
  assign send          = (state_q == ARMED) || (state_q == TX);
  assign data          = data_q;
  assign rx_len        = rx_len_q;
  assign hdr_hit       = hdr_hit_q;

endmodule

// File: tb/tb_backscatter_codec.sv
// Directed self-checking bench for backscatter_codec; the arm-timeout scenario
// is exercised when BACKSCATTER_ARM_TIMEOUT_EN is defined.
module tb_backscatter_codec;

  logic        clock = 1'b0;
  logic        reset;
  logic        trigger_signal;
  logic [7:0]  tx_payload;
  logic        output_signal;
  logic        send;
  logic [15:0] data;
  logic [4:0]  rx_len;
  logic        hdr_hit;

  int n_checks = 0;
  int n_fail   = 0;

  backscatter_codec #(.ARM_TIMEOUT(100)) dut (
    .clock          (clock),
    .reset          (reset),
    .trigger_signal (trigger_signal),
    .tx_payload     (tx_payload),
    .output_signal  (output_signal),
    .send           (send),
    .data           (data),
    .rx_len         (rx_len),
    .hdr_hit        (hdr_hit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // High for w sampled clocks, then low; returns just after the falling edge is registered.
  task automatic pulse(input int w);
    trigger_signal = 1'b1;
    repeat (w) tick();
    trigger_signal = 1'b0;
    tick();
  endtask

  // Expected registered output for envelope count c (value appears one clock later).
  function automatic logic tx_model(input int c, input logic [7:0] pay);
    int e;
    if (c <= 448 || c > 6000) return 1'b0;
    e = c - 449;
    if (e >= 4000) return 1'b0;
    return pay[7 - e / 500] & logic'((e / 25) % 2);
  endfunction

  int          bnd_w   [7] = '{399, 400, 600, 601, 1200, 1600, 1601};
  logic        bnd_ok  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int          hdr_w   [5] = '{500, 1400, 500, 1400, 500};
  int          arm_w   [4] = '{1400, 500, 1400, 500};
  logic [7:0]  pay;
  int          rl;
  int          m_pre, m_b7, m_b6, m_mid, m_post, ones7;

  initial begin
    reset          = 1'b0;
    trigger_signal = 1'b0;
    tx_payload     = 8'h00;
    pay            = 8'hA5;
    repeat (3) tick();
    check("rst_out",    32'(output_signal), 0);
    check("rst_send",   32'(send),          0);
    check("rst_data",   32'(data),          0);
    check("rst_rx_len", 32'(rx_len),        0);
    check("rst_hdr",    32'(hdr_hit),       0);
    #3 reset = 1'b1;
    tick();

    // A valid bit followed by an invalid width clears the count
    pulse(500);
    check("w500_data", 32'(data), 500);
    check("w500_len",  32'(rx_len), 1);
    tick();
    pulse(1000);
    check("w1000_data", 32'(data), 1000);
    check("w1000_len",  32'(rx_len), 0);
    check("w1000_hdr",  32'(hdr_hit), 0);
    tick();

    // Inclusive classification bounds
    rl = 0;
    for (int i = 0; i < 7; i++) begin
      pulse(bnd_w[i]);
      rl = bnd_ok[i] ? rl + 1 : 0;
      check($sformatf("bnd%0d_data", bnd_w[i]), 32'(data), 32'(bnd_w[i]));
      check($sformatf("bnd%0d_len", bnd_w[i]),  32'(rx_len), 32'(rl));
      check($sformatf("bnd%0d_hdr", bnd_w[i]),  32'(hdr_hit), 0);
      tick();
    end

    // Bits 0,1,0,1,0: last four are 1010 (first received is MSB), match on the fifth
    for (int i = 0; i < 5; i++) begin
      if (i == 4) tx_payload = 8'hA5;
      pulse(hdr_w[i]);
      check($sformatf("hdr_seq%0d_data", i), 32'(data), 32'(hdr_w[i]));
      check($sformatf("hdr_seq%0d_len", i),  32'(rx_len), 32'(i + 1));
      check($sformatf("hdr_seq%0d_hit", i),  32'(hdr_hit), (i == 4) ? 1 : 0);
      if (i < 4) tick();
    end
    check("armed_send", 32'(send), 1);
    tx_payload = 8'h00;
    tick();
    check("hdr_pulse_width", 32'(hdr_hit), 0);
    check("armed_out",       32'(output_signal), 0);
    check("armed_send_hold", 32'(send), 1);

    // 6000-clock envelope carrying 8'hA5
    m_pre = 0; m_b7 = 0; m_b6 = 0; m_mid = 0; m_post = 0; ones7 = 0;
    trigger_signal = 1'b1;
    for (int k = 1; k <= 6000; k++) begin
      logic exp_o;
      int   c;
      tick();
      c     = k - 1;
      exp_o = tx_model(c, pay);
      if (c <= 448)       m_pre  += (output_signal !== exp_o) ? 1 : 0;
      else if (c <= 948)  begin
        m_b7  += (output_signal !== exp_o) ? 1 : 0;
        ones7 += (output_signal === 1'b1) ? 1 : 0;
      end
      else if (c <= 1448) m_b6   += (output_signal !== exp_o) ? 1 : 0;
      else if (c <= 4448) m_mid  += (output_signal !== exp_o) ? 1 : 0;
      else                m_post += (output_signal !== exp_o) ? 1 : 0;
      if (k == 474) check("sc_first_low",  32'(output_signal), 0);
      if (k == 475) check("sc_first_high", 32'(output_signal), 1);
    end
    check("tx_pre_window_errs", 32'(m_pre),  0);
    check("tx_bit7_errs",       32'(m_b7),   0);
    check("tx_bit7_high_clks",  32'(ones7),  250);
    check("tx_bit6_errs",       32'(m_b6),   0);
    check("tx_bits5to0_errs",   32'(m_mid),  0);
    check("tx_exhausted_errs",  32'(m_post), 0);
    check("tx_send_high",       32'(send),   1);
    trigger_signal = 1'b0;
    check("tx_send_before_edge", 32'(send), 1);
    tick();
    check("tx_exit_send",   32'(send),          0);
    check("tx_exit_out",    32'(output_signal), 0);
    check("tx_exit_rx_len", 32'(rx_len),        0);
    check("tx_exit_data",   32'(data),          500);

    // Re-arm, then reset in the middle of TX
    tick();
    tx_payload = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      pulse(arm_w[i]);
      if (i < 3) tick();
    end
    check("rearm1_hit", 32'(hdr_hit), 1);
    tick();
    trigger_signal = 1'b1;
    repeat (1000) tick();
    check("mid_tx_send", 32'(send), 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_out",  32'(output_signal), 0);
    check("async_rst_send", 32'(send),          0);
    trigger_signal = 1'b0;
    tick();
    #3 reset = 1'b1;
    tick();
    check("post_rst_data", 32'(data),   0);
    check("post_rst_len",  32'(rx_len), 0);
    pulse(1400);
    check("post_rst_pulse_data", 32'(data),   1400);
    check("post_rst_pulse_len",  32'(rx_len), 1);
    tick();

    // Shift holds 0001; bits 0,1,0 complete 1010
    for (int i = 0; i < 3; i++) begin
      pulse(hdr_w[i]);
      if (i < 2) tick();
    end
    check("rearm2_hit",  32'(hdr_hit), 1);
    check("rearm2_send", 32'(send),    1);
`ifdef BACKSCATTER_ARM_TIMEOUT_EN
    repeat (99) tick();
    check("tmo_send_before", 32'(send), 1);
    tick();
    check("tmo_send_after", 32'(send),   0);
    check("tmo_rx_len",     32'(rx_len), 0);
    pulse(1400);
    check("tmo_next_len",  32'(rx_len), 1);
    check("tmo_next_data", 32'(data),   1400);
`else
    repeat (150) tick();
    check("armed_wait_send", 32'(send), 1);
    check("armed_wait_out",  32'(output_signal), 0);
    pulse(10);
    check("short_env_send", 32'(send),   0);
    check("short_env_len",  32'(rx_len), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
